// File: rtl/booth_pkg.sv
// Shared types and constants for the radix-2 Booth multiplier.
package booth_pkg;

  localparam int unsigned N_DEF = 4;

  typedef enum logic [1:0] {IDLE, CALC, SHIFT, DONE} state_t;

  // {Q[0], Q_1} pairs that call for an add or a subtract of M
  localparam logic [1:0] BOOTH_ADD = 2'b01;
  localparam logic [1:0] BOOTH_SUB = 2'b10;

endpackage

// File: rtl/booth_alu.sv
// Combinational Booth step: add/sub of M into ACC and the 1-bit arithmetic shift of {ACC,Q,Q_1}.
module booth_alu
  import booth_pkg::*;
#(
  parameter int unsigned N = N_DEF
) (
  input  logic [N:0]   acc_i,
  input  logic [N:0]   m_i,
  input  logic [N-1:0] q_i,
  input  logic         q1_i,
  output logic [N:0]   acc_calc_o,
  output logic [N:0]   acc_shift_o,
  output logic [N-1:0] q_shift_o,
  output logic         q1_shift_o
);

  always_comb begin
    acc_calc_o = acc_i;
    unique case ({q_i[0], q1_i})
      BOOTH_ADD: acc_calc_o = acc_i + m_i;
      BOOTH_SUB: acc_calc_o = acc_i - m_i;
      default:   acc_calc_o = acc_i;
    endcase
  end

  // ACC sign bit is replicated; Q[0] falls into Q_1
  assign {acc_shift_o, q_shift_o, q1_shift_o} = {acc_i[N], acc_i, q_i};

endmodule

// File: rtl/booth_control.sv
// Sequencer and registers for a radix-2 Booth signed multiplier: N calc/shift pairs, then
// the 2N-bit product is registered and done pulses for one cycle.
module booth_control
  import booth_pkg::*;
#(
  parameter int unsigned N = N_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           valid,
  input  logic [N-1:0]   A,
  input  logic [N-1:0]   B,
  output logic [2*N-1:0] product,
  output logic           done,
  output logic           busy
);

  localparam int unsigned CntW = $clog2(N + 1);

  state_t         state_q, state_d;
  logic [N:0]     m_q, m_d;
  logic [N:0]     acc_q, acc_d;
  logic [N-1:0]   q_q, q_d;
  logic           q1_q, q1_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2*N-1:0] product_q, product_d;
  logic           done_q, done_d;

  logic [N:0]     acc_calc, acc_shift;
  logic [N-1:0]   q_shift;
  logic           q1_shift;

  booth_alu #(
    .N(N)
  ) u_alu (
    .acc_i      (acc_q),
    .m_i        (m_q),
    .q_i        (q_q),
    .q1_i       (q1_q),
    .acc_calc_o (acc_calc),
    .acc_shift_o(acc_shift),
    .q_shift_o  (q_shift),
    .q1_shift_o (q1_shift)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      m_q       <= '0;
      acc_q     <= '0;
      q_q       <= '0;
      q1_q      <= 1'b0;
      cnt_q     <= '0;
      product_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      m_q       <= m_d;
      acc_q     <= acc_d;
      q_q       <= q_d;
      q1_q      <= q1_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    m_d       = m_q;
    acc_d     = acc_q;
    q_d       = q_q;
    q1_d      = q1_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    done_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (valid) begin
          m_d     = {A[N-1], A};
          q_d     = B;
          acc_d   = '0;
          q1_d    = 1'b0;
          cnt_d   = CntW'(N);
          state_d = CALC;
        end
      end
      CALC: begin
        acc_d   = acc_calc;
        state_d = SHIFT;
      end
      SHIFT: begin
        acc_d = acc_shift;
        q_d   = q_shift;
        q1_d  = q1_shift;
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          // Load the result on entry to DONE so product and done change together
          product_d = {acc_shift[N-1:0], q_shift};
          done_d    = 1'b1;
          state_d   = DONE;
        end else begin
          state_d = CALC;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign product = product_q;
  assign done    = done_q;
  assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_booth_control.sv
// Bench for booth_control: directed operations with literal results plus a cycle model of
// busy/done/product driven by operation timing and plain signed multiplication.
module tb_booth_control;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           valid = 1'b0;
  logic [N-1:0]   A = '0;
  logic [N-1:0]   B = '0;
  logic [2*N-1:0] product;
  logic           done;
  logic           busy;

  int checks = 0;
  int errors = 0;

  booth_control #(
    .N(N)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .valid  (valid),
    .A      (A),
    .B      (B),
    .product(product),
    .done   (done),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [2*N-1:0] ref_mul(input logic [N-1:0] a, input logic [N-1:0] b);
    logic signed [2*N-1:0] sa, sb, p;
    sa = {{N{a[N-1]}}, a};
    sb = {{N{b[N-1]}}, b};
    p  = sa * sb;
    return p;
  endfunction

  // Model: an accepted request keeps the unit busy for 2N+1 cycles, the last being done
  int             rem = 0;
  logic [2*N-1:0] m_prod = '0;
  logic [2*N-1:0] m_pend = '0;
  int             m_dones = 0;
  int             dut_dones = 0;

  always @(posedge clk) begin
    if (!rst) begin
      rem    = 0;
      m_prod = '0;
    end else if (rem > 0) begin
      rem--;
      if (rem == 1) begin
        m_prod = m_pend;
        m_dones++;
      end
    end else if (valid) begin
      rem    = 2 * N + 1;
      m_pend = ref_mul(A, B);
    end
    #1;
    check("busy", 32'(busy), 32'(rem > 0));
    check("done", 32'(done), 32'(rem == 1));
    check("product", 32'(product), 32'(m_prod));
    if (done === 1'b1) dut_dones++;
  end

  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic [2*N-1:0] exp, input string name);
    int lat;
    @(negedge clk);
    A = a;
    B = b;
    valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    lat = 0;
    for (int i = 0; i < 4 * N; i++) begin
      lat++;
      @(negedge clk);
      if (done === 1'b1) break;
    end
    check({name, " latency"}, 32'(lat), 32'(2 * N));
    check({name, " product"}, 32'(product), 32'(exp));
    check({name, " model"}, 32'(m_prod), 32'(exp));
  endtask

  initial begin
    int d0;
    repeat (2) @(negedge clk);
    check("reset product", 32'(product), 32'h0);
    check("reset busy", 32'(busy), 32'h0);
    check("reset done", 32'(done), 32'h0);
    rst = 1'b1;

    run_op(4'd3, 4'd2, 8'h06, "3x2");
    run_op(4'hD, 4'd5, 8'hF1, "-3x5");
    run_op(4'd7, 4'h8, 8'hC8, "7x-8");
    run_op(4'h8, 4'h8, 8'h40, "-8x-8");
    run_op(4'd0, 4'hF, 8'h00, "0x-1");

    // Requests arriving while busy must be dropped
    @(negedge clk);
    A = 4'd2;
    B = 4'd3;
    valid = 1'b1;
    d0 = dut_dones;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      valid = (i == 3 || i == 8);
      if (valid) begin
        A = 4'd5;
        B = 4'd5;
      end
    end
    check("busy-inject done count", 32'(dut_dones - d0), 32'd1);
    check("busy-inject product", 32'(product), 32'h06);

    // Reset in the middle of an operation
    @(negedge clk);
    A = 4'd7;
    B = 4'd7;
    valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid-reset product", 32'(product), 32'h0);
    check("mid-reset busy", 32'(busy), 32'h0);
    check("mid-reset done", 32'(done), 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    run_op(4'd1, 4'd1, 8'h01, "1x1");

    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        run_op(4'(a), 4'(b), ref_mul(4'(a), 4'(b)), "sweep");
      end
    end

    @(negedge clk);
    check("total done count", 32'(dut_dones), 32'(m_dones));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/booth_control.md
Name: booth_control

Overview:
Sequencer and datapath for a radix-2 Booth signed multiplier.
- Consumes the synchronized operands `_A`/`_B` and the one-cycle `valid` pulse produced by the input subsystem.
- Runs N add/subtract + arithmetic-shift iterations.
- Registers the 2N-bit signed product and pulses `done`.
- Sits between the input subsystem and the output/display stage.

Parameters:
- N, 4, operand width in bits (signed two's complement); product is 2N bits.

Ports:
- clk  input  1  system clock; all state on rising edge
- rst  input  1  asynchronous, active-low reset
- valid  input  1  start pulse, one clk wide; sampled only in IDLE
- A  input  N  multiplicand, signed; captured when valid accepted
- B  input  N  multiplier, signed; captured when valid accepted
- product  output  2N  signed result; held until next completion
- done  output  1  one-cycle pulse when product updates
- busy  output  1  high while an operation is in progress (CALC/SHIFT/DONE)

Behaviour:
- Reset (rst=0, async): state=IDLE, product=0, done=0, busy=0; all internal regs (M, ACC, Q, Q_1, CNT) cleared.
- Internal registers:
  - M: N+1 bits, sign-extended A.
  - ACC: N+1 bits. The extra bit is mandatory so that -M for A = -2^(N-1) is representable.
  - Q: N bits, the multiplier.
  - Q_1: 1 bit.
  - CNT: clog2(N+1) bits.
- IDLE:
  - busy=0.
  - If valid=1: M<=sext(A), Q<=B, ACC<=0, Q_1<=0, CNT<=N; go to CALC.
  - Else stay in IDLE.
- CALC (one cycle), selected by {Q[0],Q_1}:
  - 01: ACC<=ACC+M.
  - 10: ACC<=ACC-M.
  - 00/11: ACC unchanged.
  - Next state: SHIFT.
- SHIFT (one cycle):
  - {ACC,Q,Q_1} <= arithmetic right shift by 1; ACC MSB is replicated.
  - CNT<=CNT-1.
  - If CNT==1 go to DONE, else go to CALC.
- DONE (one cycle):
  - product<={ACC[N-1:0],Q}; done=1 (registered, high exactly this cycle); next state IDLE.
- Latency:
  - valid sampled at edge k → done high during cycle k+2N+1 (N=4: 9 cycles).
  - A back-to-back valid is accepted no earlier than the cycle after DONE.
- valid while busy=1: ignored. Not queued, no effect on the current operation or its operands.
- A/B changing after acceptance: no effect; operands are latched at acceptance.
- Arithmetic is modulo 2^(N+1) in ACC. The product is exact for every signed pair, including (-2^(N-1))×(-2^(N-1)) = +2^(2N-2).
- Reset asserted mid-operation: immediate return to the reset state. The partial result is discarded, product is cleared to 0, and no done pulse is issued.
- done and busy are mutually consistent: done=1 implies busy=1.

Decomposition:
- Package booth_pkg:
  - state enum {IDLE, CALC, SHIFT, DONE}.
  - default operand width constant N_DEF=4.
  - Booth-pair encoding constants (BOOTH_ADD=2'b01, BOOTH_SUB=2'b10).
- One natural sub-module, booth_alu (combinational): takes ACC, M and {Q[0],Q_1}; returns the next ACC for the CALC step and the shifted {ACC,Q,Q_1} for the SHIFT step.
- FSM, counter and registers stay in booth_control.

Test Plan:
- Reset, then A=3, B=2, valid pulse → busy rises the next cycle; done pulses 9 cycles after valid; product=8'h06.
- A=-3 (4'hD), B=5 → product=8'hF1 (-15); A=7, B=-8 (4'h8) → product=8'hC8 (-56).
- Corner case A=-8, B=-8 → product=8'h40 (+64); A=0, B=-1 → product=8'h00.
- Start A=2, B=3; inject valid with A=5, B=5 at cycles 3 and 8 while busy → first result 8'h06, exactly one done pulse, second request never executed.
- Start A=7, B=7; drive rst=0 at cycle 4 → product=0, busy=0, done=0 immediately. Release, then A=1, B=1 → product=8'h01.
- Exhaustive sweep of all 256 signed A×B pairs, with valid issued one cycle after each done → every product equals the signed reference; exactly one done per valid accepted.
